// File: rtl/enemy_blt_ctrl.sv
// Enemy bullet slot manager: allocates up to 15 bullets on fire requests and
// advances/retires them once per frame for the bullet pixel generator.
module enemy_blt_ctrl #(
   parameter int BLT_SPEED     = 3,
   parameter int Y_MAX         = 465,
   parameter int FIRE_COOLDOWN = 4
) (
   input  logic         clk_25MHz,
   input  logic         rst_n,
   input  logic         frame_tick,
   input  logic         fire_req,
   input  logic [8:0]   fire_x,
   input  logic [8:0]   fire_y,
   input  logic [14:0]  hit_clear,
   input  logic         game_clear,
   output logic [134:0] enemy_blt_x,
   output logic [134:0] enemy_blt_y,
   output logic [14:0]  enemy_blt_vi,
   output logic         fire_ack,
   output logic         fire_drop,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, ALLOC, UPDATE, RESP} state_t;

   state_t      state;
   state_t      next_state;
   logic [3:0]  idx;
   logic [7:0]  cooldown;
   logic [3:0]  free_idx;
   logic        free_found;
   logic        accept;
   logic        ack_next;
   logic        drop_next;
   logic [8:0]  cur_y;
   logic [9:0]  sum_y;
   logic        retire;
   logic [14:0] vi_next;

   // Lowest-numbered dead slot, searched from the registered visibility bits
   always_comb begin
      free_found = 1'b0;
      free_idx   = 4'd0;
      for (int i = 14; i >= 0; i--) begin
         if (!enemy_blt_vi[i]) begin
            free_found = 1'b1;
            free_idx   = 4'(i);
         end
      end
   end

   always_comb begin
      cur_y  = enemy_blt_y[int'(idx) * 9 +: 9];
      sum_y  = {1'b0, cur_y} + 10'(BLT_SPEED);
      retire = (sum_y > 10'(Y_MAX));
   end

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      ack_next   = 1'b0;
      drop_next  = 1'b0;
      case (state)
         IDLE: begin
            if (frame_tick)
               next_state = UPDATE;
            else if (fire_req)
               next_state = ALLOC;
         end
         ALLOC: begin
            accept     = (cooldown == 8'd0) && free_found && !game_clear;
            ack_next   = accept;
            drop_next  = !accept;
            next_state = RESP;
         end
         UPDATE: begin
            if (idx == 4'd14)
               next_state = IDLE;
         end
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Allocation overrides a same-cycle hit on its slot; game_clear overrides all
   always_comb begin
      vi_next = enemy_blt_vi;
      if (state == UPDATE && enemy_blt_vi[idx] && retire)
         vi_next[idx] = 1'b0;
      vi_next = vi_next & ~hit_clear;
      if (accept)
         vi_next[free_idx] = 1'b1;
      if (game_clear)
         vi_next = '0;
   end

   assign busy = (state == UPDATE);

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= 4'd0;
         cooldown  <= 8'd0;
         fire_ack  <= 1'b0;
         fire_drop <= 1'b0;
      end else begin
         idx       <= (state == UPDATE) ? idx + 4'd1 : 4'd0;
         fire_ack  <= ack_next;
         fire_drop <= drop_next;
         if (game_clear)
            cooldown <= 8'd0;
         else if (accept)
            cooldown <= 8'(FIRE_COOLDOWN);
         else if (frame_tick && cooldown != 8'd0)
            cooldown <= cooldown - 8'd1;
      end
   end

   // Slot storage: x only changes on allocation, y on allocation or a walk step
   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         enemy_blt_x  <= '0;
         enemy_blt_y  <= '0;
         enemy_blt_vi <= '0;
      end else begin
         enemy_blt_vi <= vi_next;
         if (accept) begin
            enemy_blt_x[int'(free_idx) * 9 +: 9] <= fire_x;
            enemy_blt_y[int'(free_idx) * 9 +: 9] <= fire_y;
         end else if (state == UPDATE && enemy_blt_vi[idx] && !hit_clear[idx] && !retire) begin
            enemy_blt_y[int'(idx) * 9 +: 9] <= sum_y[8:0];
         end
      end
   end

endmodule

// File: tb/tb_enemy_blt_ctrl.sv
// Self-checking bench for enemy_blt_ctrl: directed scenarios plus random
// operations compared against an array-based model of the bullet slots.
module tb_enemy_blt_ctrl;

   localparam int SPEED = 3;
   localparam int YMAX  = 465;
   localparam int COOL  = 4;

   logic         clk_25MHz = 1'b0;
   logic         rst_n = 1'b0;
   logic         frame_tick = 1'b0;
   logic         fire_req = 1'b0;
   logic [8:0]   fire_x = '0;
   logic [8:0]   fire_y = '0;
   logic [14:0]  hit_clear = '0;
   logic         game_clear = 1'b0;
   logic [134:0] enemy_blt_x;
   logic [134:0] enemy_blt_y;
   logic [14:0]  enemy_blt_vi;
   logic         fire_ack;
   logic         fire_drop;
   logic         busy;

   int checkCount = 0;
   int failCount  = 0;

   int mx[15];
   int my[15];
   bit mv[15];
   int mcool;

   enemy_blt_ctrl #(.BLT_SPEED(SPEED), .Y_MAX(YMAX), .FIRE_COOLDOWN(COOL)) dut (
      .clk_25MHz(clk_25MHz), .rst_n(rst_n), .frame_tick(frame_tick),
      .fire_req(fire_req), .fire_x(fire_x), .fire_y(fire_y),
      .hit_clear(hit_clear), .game_clear(game_clear),
      .enemy_blt_x(enemy_blt_x), .enemy_blt_y(enemy_blt_y), .enemy_blt_vi(enemy_blt_vi),
      .fire_ack(fire_ack), .fire_drop(fire_drop), .busy(busy)
   );

   always #20 clk_25MHz = ~clk_25MHz;

   task automatic checkOutput(input string tag, input logic [134:0] observed, input logic [134:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [14:0] modelVi();
      logic [14:0] v = '0;
      for (int i = 0; i < 15; i++) v[i] = mv[i];
      return v;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 15; i++) begin
         mv[i] = 1'b0;
         mx[i] = 0;
         my[i] = 0;
      end
      mcool = 0;
   endtask

   task automatic compareModel(input string tag);
      checkOutput({tag, " vi"}, 135'(enemy_blt_vi), 135'(modelVi()));
      for (int i = 0; i < 15; i++) begin
         if (mv[i]) begin
            checkOutput($sformatf("%s x%0d", tag, i), 135'(enemy_blt_x[i*9 +: 9]), 135'(mx[i]));
            checkOutput($sformatf("%s y%0d", tag, i), 135'(enemy_blt_y[i*9 +: 9]), 135'(my[i]));
         end
      end
   endtask

   task automatic fireRequest(input int x, input int y, input logic [14:0] mask);
      int slot = -1;
      bit expAcc;
      for (int i = 0; i < 15; i++) if (!mv[i] && slot < 0) slot = i;
      expAcc   = (mcool == 0) && (slot >= 0);
      fire_req = 1'b1;
      fire_x   = 9'(x);
      fire_y   = 9'(y);
      @(posedge clk_25MHz) #1;
      hit_clear = mask;
      @(posedge clk_25MHz) #1;
      hit_clear = '0;
      fire_req  = 1'b0;
      checkOutput("fire_ack", 135'(fire_ack), 135'(expAcc));
      checkOutput("fire_drop", 135'(fire_drop), 135'(!expAcc));
      for (int i = 0; i < 15; i++) if (mask[i]) mv[i] = 1'b0;
      if (expAcc) begin
         mv[slot] = 1'b1;
         mx[slot] = x;
         my[slot] = y;
         mcool    = COOL;
      end
      @(posedge clk_25MHz) #1;
      checkOutput("resp one cycle", 135'({fire_ack, fire_drop}), 135'(0));
   endtask

   task automatic frameTick();
      int cnt = 0;
      frame_tick = 1'b1;
      @(posedge clk_25MHz) #1;
      frame_tick = 1'b0;
      while (busy && cnt < 40) begin
         cnt++;
         @(posedge clk_25MHz) #1;
      end
      checkOutput("busy cycles", 135'(cnt), 135'(15));
      if (mcool > 0) mcool--;
      for (int i = 0; i < 15; i++) begin
         if (mv[i]) begin
            if (my[i] + SPEED > YMAX) mv[i] = 1'b0;
            else my[i] = my[i] + SPEED;
         end
      end
   endtask

   task automatic pulseHit(input logic [14:0] mask);
      hit_clear = mask;
      @(posedge clk_25MHz) #1;
      hit_clear = '0;
      for (int i = 0; i < 15; i++) if (mask[i]) mv[i] = 1'b0;
   endtask

   task automatic pulseGameClear();
      game_clear = 1'b1;
      @(posedge clk_25MHz) #1;
      game_clear = 1'b0;
      for (int i = 0; i < 15; i++) mv[i] = 1'b0;
      mcool = 0;
   endtask

   task automatic applyStimulus();
      int op = $urandom_range(0, 9);
      logic [14:0] mask;
      if (op < 4) begin
         mask = ($urandom_range(0, 3) == 0) ? 15'($urandom) : 15'h0;
         fireRequest($urandom_range(0, 319), $urandom_range(0, YMAX), mask);
      end else if (op < 8) begin
         frameTick();
      end else if (op == 8) begin
         pulseHit(15'($urandom));
      end else begin
         pulseGameClear();
      end
   endtask

   initial begin
      modelReset();
      repeat (2) @(posedge clk_25MHz);
      #1;
      checkOutput("reset vi", 135'(enemy_blt_vi), 135'(0));
      checkOutput("reset x", enemy_blt_x, 135'(0));
      checkOutput("reset y", enemy_blt_y, 135'(0));
      checkOutput("reset ack/drop/busy", 135'({fire_ack, fire_drop, busy}), 135'(0));
      rst_n = 1'b1;
      @(posedge clk_25MHz) #1;

      fireRequest(100, 20, 15'h0);
      checkOutput("first fire vi", 135'(enemy_blt_vi), 135'(15'h0001));
      compareModel("first fire");
      frameTick();
      checkOutput("slot0 y after frame", 135'(enemy_blt_y[8:0]), 135'(23));
      checkOutput("slot0 x after frame", 135'(enemy_blt_x[8:0]), 135'(100));

      frameTick();
      fireRequest(50, 50, 15'h0);
      compareModel("cooldown drop");
      frameTick();
      frameTick();
      fireRequest(200, 463, 15'h0);
      compareModel("cooldown done");
      frameTick();
      checkOutput("retired vi1", 135'(enemy_blt_vi[1]), 135'(0));
      checkOutput("retired y held", 135'(enemy_blt_y[17:9]), 135'(463));
      compareModel("retire");

      pulseGameClear();
      checkOutput("game_clear vi", 135'(enemy_blt_vi), 135'(0));
      fireRequest(7, 462, 15'h0);
      frameTick();
      checkOutput("edge y 465", 135'(enemy_blt_y[8:0]), 135'(465));
      checkOutput("edge vi", 135'(enemy_blt_vi[0]), 135'(1));
      frameTick();
      compareModel("edge retire");

      pulseGameClear();
      for (int k = 0; k < 15; k++) begin
         fireRequest(10 + k * 20, k * 5, 15'h0);
         repeat (4) frameTick();
      end
      fireRequest(300, 300, 15'h0);
      checkOutput("full vi", 135'(enemy_blt_vi), 135'(15'h7FFF));
      compareModel("full");

      pulseGameClear();
      for (int k = 0; k < 3; k++) begin
         fireRequest(30 + k, 40 + k, 15'h0);
         repeat (4) frameTick();
      end
      fireRequest(99, 99, 15'h0002);
      checkOutput("hit during alloc vi", 135'(enemy_blt_vi), 135'(15'h000D));
      checkOutput("hit during alloc x3", 135'(enemy_blt_x[35:27]), 135'(99));
      compareModel("hit during alloc");

      frame_tick = 1'b1;
      @(posedge clk_25MHz) #1;
      frame_tick = 1'b0;
      repeat (7) @(posedge clk_25MHz);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async reset vi", 135'(enemy_blt_vi), 135'(0));
      checkOutput("async reset busy", 135'(busy), 135'(0));
      #5;
      rst_n = 1'b1;
      modelReset();
      @(posedge clk_25MHz) #1;
      fireRequest(150, 100, 15'h0);
      frameTick();
      compareModel("after reset");

      for (int n = 0; n < 120; n++) begin
         applyStimulus();
         compareModel($sformatf("random %0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
